// File: rtl/tetris_pkg.sv
// Shared geometry, widths and FSM encoding for the single-cell drop game.
// Row r occupies bits [r*16 +: 16]; column c is bit c within that row word.
package tetris_pkg;

    localparam logic [15:0]  LINE0    = 16'h03FF;
    localparam logic [15:0]  LINE1    = 16'h0200;
    localparam logic [127:0] WALL_MAP = {LINE0, {6{LINE1}}, LINE0};

    localparam int ROW_W = 3;
    localparam int COL_W = 4;

    localparam logic [ROW_W-1:0] FLOOR_ROW = 3'd7;
    localparam logic [COL_W-1:0] COL_MAX   = 4'd8;

    typedef enum logic [2:0] {
        SPAWN = 3'd0,
        PLAY  = 3'd1,
        LOCK  = 3'd2,
        CLEAR = 3'd3,
        OVER  = 3'd4
    } state_t;

    function automatic logic [6:0] cell_idx(input logic [ROW_W-1:0] row,
                                            input logic [COL_W-1:0] col);
        return {row, col};
    endfunction

endpackage

// File: rtl/btn_edge.sv
// Two-flop synchronizer for a raw button level followed by a one-cycle
// rising-edge pulse.
module btn_edge (
    input  logic Clk,
    input  logic Reset,
    input  logic Btn,
    output logic Pulse
);

    logic sync1_reg;
    logic sync2_reg;
    logic sync3_reg;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            sync1_reg <= 1'b0;
            sync2_reg <= 1'b0;
            sync3_reg <= 1'b0;
        end else begin
            sync1_reg <= Btn;
            sync2_reg <= sync1_reg;
            sync3_reg <= sync2_reg;
        end
    end

    assign Pulse = sync2_reg & ~sync3_reg;

endmodule

// File: rtl/drop_controller.sv
// Playfield sequencer: spawns a single-cell piece, applies moves and gravity,
// locks it, clears full rows, keeps score and drives the registered Map.
module drop_controller #(
    parameter int TICK_DIV  = 25000000,
    parameter int SPAWN_COL = 4
) (
    input  logic         Clk,
    input  logic         Reset,
    input  logic         Btnl,
    input  logic         Btnr,
    input  logic         Start,
    output logic [127:0] Map,
    output logic [7:0]   Score,
    output logic         GameOver
);
    import tetris_pkg::*;

    localparam int TICK_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
    localparam logic [COL_W-1:0]  SPAWN_C   = COL_W'(SPAWN_COL);

    state_t state_reg, state_next;

    logic [127:0]      field_reg, field_next;
    logic [ROW_W-1:0]  row_reg, row_next;
    logic [COL_W-1:0]  col_reg, col_next;
    logic              valid_reg, valid_next;
    logic              pend_l_reg, pend_l_next;
    logic              pend_r_reg, pend_r_next;
    logic              fall_reg, fall_next;
    logic [TICK_W-1:0] tick_reg, tick_next;
    logic [ROW_W-1:0]  scan_reg, scan_next;
    logic [7:0]        score_reg, score_next;
    logic [127:0]      map_reg, map_next;

    logic [1:0]   btn_raw;
    logic [1:0]   btn_pulse;
    logic [7:0]   row_full;
    logic [127:0] shifted_field;

    genvar gi;

    assign btn_raw = {Btnr, Btnl};

    generate
        for (gi = 0; gi < 2; gi++) begin : g_btn
            btn_edge u_edge (
                .Clk   (Clk),
                .Reset (Reset),
                .Btn   (btn_raw[gi]),
                .Pulse (btn_pulse[gi])
            );
        end

        // Candidate field for a clear at row scan_reg: rows 1..scan move down one.
        for (gi = 0; gi < 8; gi++) begin : g_rows
            if (gi == 0 || gi == 7) begin : g_edge_row
                assign row_full[gi] = 1'b0;
                assign shifted_field[gi*16 +: 16] = field_reg[gi*16 +: 16];
            end else if (gi == 1) begin : g_top_row
                assign row_full[gi] = &field_reg[gi*16 +: 9];
                assign shifted_field[gi*16 +: 16] = 16'h0000;
            end else begin : g_mid_row
                assign row_full[gi] = &field_reg[gi*16 +: 9];
                assign shifted_field[gi*16 +: 16] = (3'(gi) <= scan_reg) ?
                    field_reg[(gi-1)*16 +: 16] : field_reg[gi*16 +: 16];
            end
        end
    endgenerate

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) state_reg <= SPAWN;
        else       state_reg <= state_next;
    end

    always_comb begin
        state_next  = state_reg;
        field_next  = field_reg;
        row_next    = row_reg;
        col_next    = col_reg;
        valid_next  = valid_reg;
        pend_l_next = pend_l_reg | btn_pulse[0];
        pend_r_next = pend_r_reg | btn_pulse[1];
        fall_next   = fall_reg;
        tick_next   = tick_reg;
        scan_next   = scan_reg;
        score_next  = score_reg;
        case (state_reg)
            SPAWN: begin
                if (field_reg[cell_idx(3'd1, SPAWN_C)]) begin
                    state_next = OVER;
                end else begin
                    row_next   = 3'd1;
                    col_next   = SPAWN_C;
                    valid_next = 1'b1;
                    tick_next  = '0;
                    state_next = PLAY;
                end
            end
            PLAY: begin
                if (tick_reg == TICK_LAST) begin
                    tick_next = '0;
                    fall_next = 1'b1;
                end else begin
                    tick_next = tick_reg + TICK_W'(1);
                end
                // A pending move always wins the cycle; gravity waits one cycle.
                if (pend_l_reg || pend_r_reg) begin
                    pend_l_next = btn_pulse[0];
                    pend_r_next = btn_pulse[1];
                    if (pend_l_reg && !pend_r_reg && col_reg != 4'd0 &&
                        !field_reg[cell_idx(row_reg, col_reg - 4'd1)])
                        col_next = col_reg - 4'd1;
                    else if (pend_r_reg && !pend_l_reg && col_reg != COL_MAX &&
                             !field_reg[cell_idx(row_reg, col_reg + 4'd1)])
                        col_next = col_reg + 4'd1;
                end else if (fall_reg) begin
                    fall_next = (tick_reg == TICK_LAST);
                    if ((row_reg + 3'd1) == FLOOR_ROW ||
                        field_reg[cell_idx(row_reg + 3'd1, col_reg)])
                        state_next = LOCK;
                    else
                        row_next = row_reg + 3'd1;
                end
            end
            LOCK: begin
                field_next[cell_idx(row_reg, col_reg)] = 1'b1;
                valid_next = 1'b0;
                scan_next  = 3'd6;
                state_next = CLEAR;
            end
            CLEAR: begin
                if (row_full[scan_reg]) begin
                    field_next = shifted_field;
                    score_next = (score_reg == 8'hFF) ? score_reg : score_reg + 8'd1;
                end else begin
                    scan_next = scan_reg - 3'd1;
                    if (scan_reg <= 3'd1) state_next = SPAWN;
                end
            end
            OVER: begin
                valid_next  = 1'b0;
                pend_l_next = 1'b0;
                pend_r_next = 1'b0;
                fall_next   = 1'b0;
                if (Start) begin
                    field_next = '0;
                    score_next = 8'd0;
                    state_next = SPAWN;
                end
            end
            default: state_next = SPAWN;
        endcase
    end

    always_comb begin
        map_next = WALL_MAP | field_reg;
        if (valid_reg) map_next = map_next | ({127'b0, 1'b1} << cell_idx(row_reg, col_reg));
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            field_reg  <= '0;
            row_reg    <= '0;
            col_reg    <= '0;
            valid_reg  <= 1'b0;
            pend_l_reg <= 1'b0;
            pend_r_reg <= 1'b0;
            fall_reg   <= 1'b0;
            tick_reg   <= '0;
            scan_reg   <= '0;
            score_reg  <= 8'd0;
            map_reg    <= WALL_MAP;
        end else begin
            field_reg  <= field_next;
            row_reg    <= row_next;
            col_reg    <= col_next;
            valid_reg  <= valid_next;
            pend_l_reg <= pend_l_next;
            pend_r_reg <= pend_r_next;
            fall_reg   <= fall_next;
            tick_reg   <= tick_next;
            scan_reg   <= scan_next;
            score_reg  <= score_next;
            map_reg    <= map_next;
        end
    end

    assign Map      = map_reg;
    assign Score    = score_reg;
    assign GameOver = (state_reg == OVER);

endmodule
